// File: rtl/uart_rx_ctrl_if.sv
// Signal bundle between uart_rx_ctrl (master) and its line, sampler and command-decoder neighbours (slave).
// With UART_RX_BREAK_DETECT_EN defined the bundle also carries o_break.
interface uart_rx_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  i_rx;
    logic                  i_sampled_bit;
    logic [4:0]            i_prescale;
    logic                  i_par_en;
    logic                  i_par_typ;
    logic                  o_en_samp;
    logic [4:0]            o_edge_cnt;
    logic [DATA_WIDTH-1:0] o_p_data;
    logic                  o_data_valid;
    logic                  o_par_err;
    logic                  o_stp_err;
`ifdef UART_RX_BREAK_DETECT_EN
    logic                  o_break;

    modport master (
        input  i_rx, i_sampled_bit, i_prescale, i_par_en, i_par_typ,
        output o_en_samp, o_edge_cnt, o_p_data, o_data_valid, o_par_err, o_stp_err, o_break
    );
    modport slave (
        output i_rx, i_sampled_bit, i_prescale, i_par_en, i_par_typ,
        input  o_en_samp, o_edge_cnt, o_p_data, o_data_valid, o_par_err, o_stp_err, o_break
    );
`else
    modport master (
        input  i_rx, i_sampled_bit, i_prescale, i_par_en, i_par_typ,
        output o_en_samp, o_edge_cnt, o_p_data, o_data_valid, o_par_err, o_stp_err
    );
    modport slave (
        output i_rx, i_sampled_bit, i_prescale, i_par_en, i_par_typ,
        input  o_en_samp, o_edge_cnt, o_p_data, o_data_valid, o_par_err, o_stp_err
    );
`endif
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART RX control: drives the bit sampler and deserialises start/data/[parity]/stop into o_p_data (macro UART_RX_BREAK_DETECT_EN adds o_break + BREAK wait).
// Latency: result pulses 1 + (2+DATA_WIDTH+par)*prescale cycles after the cycle in which a low i_rx is sampled in IDLE.
// Backpressure: none; o_data_valid/o_par_err/o_stp_err are single-cycle pulses and o_p_data holds until the next good frame.
module uart_rx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic           i_clk,
    input  logic           i_rst,
    uart_rx_ctrl_if.master rx_if
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
`ifdef UART_RX_BREAK_DETECT_EN
        ,
        S_BREAK
`endif
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [4:0]            edge_cnt;
    logic [4:0]            prescale_lat;
    logic [3:0]            bit_cnt;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] shift_nxt;
    logic [DATA_WIDTH-1:0] p_data;
    logic                  par_fail;
    logic                  en_samp;
    logic                  data_valid;
    logic                  par_err;
    logic                  stp_err;

    logic                  active;
    logic                  start_det;
    logic                  bit_end;
    logic                  last_data;
    logic                  stop_end;
    logic                  par_exp;
    logic                  is_break;
    logic                  en_samp_nxt;
    logic                  data_valid_nxt;
    logic                  par_err_nxt;
    logic                  stp_err_nxt;

    assign active    = (state == S_START) || (state == S_DATA) ||
                       (state == S_PARITY) || (state == S_STOP);
    assign start_det = (state == S_IDLE) && !rx_if.i_rx;
    // The sampler's vote is only trusted on the last oversample of a bit.
    assign bit_end   = active && (edge_cnt == prescale_lat - 5'd1);
    assign last_data = (bit_cnt == 4'(DATA_WIDTH - 1));
    assign stop_end  = (state == S_STOP) && bit_end;
    assign par_exp   = rx_if.i_par_typ ? ~^shift_reg : ^shift_reg;

`ifdef UART_RX_BREAK_DETECT_EN
    assign is_break  = !rx_if.i_sampled_bit && (shift_reg == '0);
`else
    assign is_break  = 1'b0;
`endif

    generate
        if (DATA_WIDTH == 1) begin : g_shift_one
            assign shift_nxt = rx_if.i_sampled_bit;
        end else begin : g_shift_wide
            assign shift_nxt = {rx_if.i_sampled_bit, shift_reg[DATA_WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (!rx_if.i_rx) state_nxt = S_START;
            S_START:  if (bit_end) state_nxt = rx_if.i_sampled_bit ? S_IDLE : S_DATA;
            S_DATA:   if (bit_end && last_data) state_nxt = rx_if.i_par_en ? S_PARITY : S_STOP;
            S_PARITY: if (bit_end) state_nxt = S_STOP;
`ifdef UART_RX_BREAK_DETECT_EN
            S_STOP:   if (bit_end) state_nxt = is_break ? S_BREAK : S_IDLE;
            S_BREAK:  if (rx_if.i_rx) state_nxt = S_IDLE;
`else
            S_STOP:   if (bit_end) state_nxt = S_IDLE;
`endif
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        en_samp_nxt    = (state_nxt == S_START) || (state_nxt == S_DATA) ||
                         (state_nxt == S_PARITY) || (state_nxt == S_STOP);
        data_valid_nxt = stop_end && !par_fail && rx_if.i_sampled_bit;
        par_err_nxt    = stop_end && par_fail;
        stp_err_nxt    = stop_end && !rx_if.i_sampled_bit && !is_break;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            edge_cnt     <= '0;
            prescale_lat <= '0;
            bit_cnt      <= '0;
            shift_reg    <= '0;
            par_fail     <= 1'b0;
            p_data       <= '0;
            en_samp      <= 1'b0;
            data_valid   <= 1'b0;
            par_err      <= 1'b0;
            stp_err      <= 1'b0;
        end else begin
            if (start_det) begin
                prescale_lat <= rx_if.i_prescale;
                par_fail     <= 1'b0;
            end
            if (!active || bit_end) begin
                edge_cnt <= '0;
            end else begin
                edge_cnt <= edge_cnt + 5'd1;
            end
            if ((state == S_START) && bit_end) begin
                bit_cnt <= '0;
            end else if ((state == S_DATA) && bit_end) begin
                bit_cnt   <= bit_cnt + 4'd1;
                shift_reg <= shift_nxt;
            end
            if ((state == S_PARITY) && bit_end && (rx_if.i_sampled_bit != par_exp)) begin
                par_fail <= 1'b1;
            end
            en_samp    <= en_samp_nxt;
            data_valid <= data_valid_nxt;
            par_err    <= par_err_nxt;
            stp_err    <= stp_err_nxt;
            if (data_valid_nxt) begin
                p_data <= shift_reg;
            end
        end
    end

`ifdef UART_RX_BREAK_DETECT_EN
    logic brk;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            brk <= 1'b0;
        end else begin
            brk <= stop_end && is_break;
        end
    end

    assign rx_if.o_break = brk;
`endif

    assign rx_if.o_en_samp    = en_samp;
    assign rx_if.o_edge_cnt   = edge_cnt;
    assign rx_if.o_p_data     = p_data;
    assign rx_if.o_data_valid = data_valid;
    assign rx_if.o_par_err    = par_err;
    assign rx_if.o_stp_err    = stp_err;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: builds a whole line/sampler stimulus up front, derives expected outputs frame by frame, then compares every cycle.
`timescale 1ns/1ps
module tb_uart_rx_ctrl;
    localparam int W = 8;
    localparam int N = 24000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_rx_ctrl_if #(.DATA_WIDTH(W)) rx_if ();
    uart_rx_ctrl #(.DATA_WIDTH(W)) dut (.i_clk(clk), .i_rst(rst), .rx_if(rx_if.master));

    bit rx_a [N];
    bit samp_a [N];
    bit rst_a [N];
    bit pe_a [N];
    bit pt_a [N];
    int presc_a [N];
    bit e_en [N];
    bit e_val [N];
    bit e_par [N];
    bit e_stp [N];
    bit e_brk [N];
    int e_edge [N];
    int e_dat [N];
    int ld_val [N];

    typedef struct { int cyc; int en; int val; int par; int stp; int brk; int dat; } lit_t;
    lit_t lits [$];

    int cur;
    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input int c, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, c, got, exp);
        end
    endtask

    task automatic add_lit(input int c, input int en, input int val, input int par, input int stp,
                           input int brk, input int dat);
        lit_t l;
        l.cyc = c; l.en = en; l.val = val; l.par = par; l.stp = stp; l.brk = brk; l.dat = dat;
        lits.push_back(l);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            rx_a[cur] = 1'b1;
            cur++;
        end
    endtask

    task automatic put_bit(input bit b, input int p, input bit pe, input bit pt);
        for (int i = 0; i < p; i++) begin
            rx_a[cur] = b; presc_a[cur] = p; pe_a[cur] = pe; pt_a[cur] = pt;
            cur++;
        end
    endtask

    // Line frame: start, data LSB first, optional parity (pflip corrupts it), stop.
    task automatic send(input int p, input int d, input bit pe, input bit pt, input bit pflip,
                        input bit stp, output int t_fall);
        bit [7:0] dv;
        dv = d[7:0];
        t_fall = cur;
        put_bit(1'b0, p, pe, pt);
        for (int i = 0; i < W; i++) put_bit(dv[i], p, pe, pt);
        if (pe) put_bit((^dv) ^ pt ^ pflip, p, pe, pt);
        put_bit(stp, p, pe, pt);
    endtask

    // Frame-level reference: the bit k vote is the sampler value on the last cycle of bit k.
    function automatic void run_model();
        int e, s, p, f, r, nb, pe, c, ld;
        bit [7:0] d;
        bit pfail, stp, brk;
        for (int i = 0; i < N; i++) begin
            e_en[i] = 0; e_val[i] = 0; e_par[i] = 0; e_stp[i] = 0; e_brk[i] = 0;
            e_edge[i] = 0; ld_val[i] = 0;
        end
        e = 1;
        while (e < N - 700) begin
            if (rst_a[e-1] || rx_a[e-1]) begin
                e++;
                continue;
            end
            s = e; p = presc_a[s-1];
            d = '0; pfail = 0; stp = 1; brk = 0; nb = 0;
            if (samp_a[s+p-1]) begin
                f = s + p;
            end else begin
                for (int i = 0; i < W; i++) d[i] = samp_a[s+(2+i)*p-1];
                pe = int'(pe_a[s+(1+W)*p-1]);
                if (pe == 1) pfail = (samp_a[s+(2+W)*p-1] != ((^d) ^ pt_a[s+(2+W)*p-1]));
                nb = 2 + W + pe;
                f = s + nb * p;
                stp = samp_a[f-1];
`ifdef UART_RX_BREAK_DETECT_EN
                brk = (d == 8'h00) && !stp;
`endif
            end
            r = f + 1;
            for (int i = s; i <= f; i++) begin
                if (rst_a[i]) begin
                    r = i;
                    break;
                end
            end
            for (int i = s; i < f && i < r; i++) begin
                e_en[i] = 1;
                e_edge[i] = (i - s) % p;
            end
            if (r <= f) begin
                e = r + 1;
            end else begin
                if (nb != 0) begin
                    e_par[f] = pfail;
                    e_stp[f] = !stp && !brk;
                    e_brk[f] = brk;
                    e_val[f] = !pfail && stp;
                    ld_val[f] = int'(d);
                end
                e = f + 1;
                if (brk) begin
                    c = f;
                    while (c < N - 1 && !rx_a[c] && !rst_a[c]) c++;
                    e = rst_a[c] ? c + 1 : c + 2;
                end
            end
        end
        ld = 0;
        for (int i = 0; i < N; i++) begin
            if (rst_a[i]) begin
                ld = 0;
                e_en[i] = 0; e_val[i] = 0; e_par[i] = 0; e_stp[i] = 0; e_brk[i] = 0; e_edge[i] = 0;
            end else if (e_val[i]) begin
                ld = ld_val[i];
            end
            e_dat[i] = ld;
        end
    endfunction

    task automatic drive(input int c);
        rst = rst_a[c];
        rx_if.i_rx = rx_a[c];
        rx_if.i_sampled_bit = samp_a[c];
        rx_if.i_prescale = 5'(presc_a[c]);
        rx_if.i_par_en = pe_a[c];
        rx_if.i_par_typ = pt_a[c];
    endtask

    task automatic compare(input int c);
        lit_t l;
        chk("en_samp", c, int'(rx_if.o_en_samp), int'(e_en[c]));
        chk("edge_cnt", c, int'(rx_if.o_edge_cnt), e_edge[c]);
        chk("data_valid", c, int'(rx_if.o_data_valid), int'(e_val[c]));
        chk("par_err", c, int'(rx_if.o_par_err), int'(e_par[c]));
        chk("stp_err", c, int'(rx_if.o_stp_err), int'(e_stp[c]));
        chk("p_data", c, int'(rx_if.o_p_data), e_dat[c]);
`ifdef UART_RX_BREAK_DETECT_EN
        chk("break", c, int'(rx_if.o_break), int'(e_brk[c]));
`endif
        while (lits.size() > 0 && lits[0].cyc == c) begin
            l = lits.pop_front();
            if (l.en >= 0) chk("lit_en", c, int'(rx_if.o_en_samp), l.en);
            if (l.val >= 0) chk("lit_valid", c, int'(rx_if.o_data_valid), l.val);
            if (l.par >= 0) chk("lit_par", c, int'(rx_if.o_par_err), l.par);
            if (l.stp >= 0) chk("lit_stp", c, int'(rx_if.o_stp_err), l.stp);
            if (l.dat >= 0) chk("lit_data", c, int'(rx_if.o_p_data), l.dat);
`ifdef UART_RX_BREAK_DETECT_EN
            if (l.brk >= 0) chk("lit_break", c, int'(rx_if.o_break), l.brk);
`endif
        end
    endtask

    initial begin
        int t, len, p, x, rand_start, h;
        for (int c = 0; c < N; c++) begin
            rx_a[c] = 1; presc_a[c] = 8; pe_a[c] = 0; pt_a[c] = 0; rst_a[c] = 0;
        end
        for (int c = 0; c < 4; c++) rst_a[c] = 1;
        cur = 0;
        add_lit(1, 0, 0, 0, 0, 0, 0);
        add_lit(3, 0, 0, 0, 0, 0, 0);
        idle(20);
        send(8, 'hA5, 0, 0, 0, 1, t);
        add_lit(t + 80, 1, 0, 0, 0, 0, 0);
        add_lit(t + 81, 0, 1, 0, 0, 0, 'hA5);
        idle(20);
        send(16, 'h3C, 1, 0, 0, 1, t);
        add_lit(t + 177, 0, 1, 0, 0, 0, 'h3C);
        idle(20);
        send(16, 'h3C, 1, 0, 1, 1, t);
        add_lit(t + 177, 0, 0, 1, 0, 0, 'h3C);
        idle(20);
        t = cur;
        for (int i = 0; i < 2; i++) begin
            rx_a[cur] = 0; presc_a[cur] = 8; cur++;
        end
        add_lit(t + 8, 1, 0, 0, 0, 0, 'h3C);
        add_lit(t + 9, 0, 0, 0, 0, 0, 'h3C);
        idle(20);
        send(8, 'h55, 0, 0, 0, 0, t);
        add_lit(t + 81, 0, 0, 0, 1, 0, 'h3C);
        idle(20);
        send(8, 'h55, 1, 1, 1, 0, t);
        add_lit(t + 89, 0, 0, 1, 1, 0, 'h3C);
        idle(20);
        send(8, 'hFF, 0, 0, 0, 1, t);
        rst_a[t + 43] = 1;
        add_lit(t + 42, 1, 0, 0, 0, 0, 'h3C);
        add_lit(t + 43, 0, 0, 0, 0, 0, 0);
        idle(20);
        send(8, 'h81, 0, 0, 0, 1, t);
        add_lit(t + 81, 0, 1, 0, 0, 0, 'h81);
        idle(20);
        t = cur;
        for (int i = 0; i < 120; i++) begin
            rx_a[cur] = 0; presc_a[cur] = 8; cur++;
        end
        idle(100);
`ifdef UART_RX_BREAK_DETECT_EN
        add_lit(t + 81, 0, 0, 0, 0, 1, 'h81);
        add_lit(t + 100, 0, 0, 0, 0, 0, -1);
`else
        add_lit(t + 81, 0, 0, 0, 1, 0, 'h81);
        add_lit(t + 100, 1, 0, 0, 0, 0, -1);
`endif
        send(8, 'h12, 0, 0, 0, 1, t);
        add_lit(t + 81, 0, 1, 0, 0, 0, 'h12);
        idle(20);

        rand_start = cur;
        while (cur < N - 1500) begin
            p = ($urandom_range(0, 1) == 1) ? 16 : 8;
            if ($urandom_range(0, 19) == 0) begin
                len = $urandom_range(1, 3);
                for (int i = 0; i < len; i++) begin
                    rx_a[cur] = 0; presc_a[cur] = p; cur++;
                end
                idle(p + 4);
            end else begin
                send(p, $urandom_range(0, 255), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) != 0), t);
                len = cur - t;
                if ($urandom_range(0, 29) == 0) rst_a[t + $urandom_range(0, len - 1)] = 1;
                if ($urandom_range(0, 9) == 0) begin
                    x = t + $urandom_range(0, len - 1);
                    for (int i = x; i < cur; i++) pe_a[i] = !pe_a[i];
                end
                if ($urandom_range(0, 9) == 0) begin
                    x = t + $urandom_range(1, len - 1);
                    for (int i = x; i < cur; i++) presc_a[i] = 24 - p;
                end
            end
            idle($urandom_range(0, 12));
        end

        // Sampler stand-in: mid-bit value of the line, with rare vote errors in the random section.
        for (int c = 0; c < N; c++) begin
            h = presc_a[c] / 2;
            samp_a[c] = (c >= h) ? rx_a[c - h] : 1'b1;
            if (c >= rand_start && $urandom_range(0, 299) == 0) samp_a[c] = !samp_a[c];
        end
        run_model();

        foreach (lits[i]) begin
            if (lits[i].en >= 0) chk("model_en", lits[i].cyc, int'(e_en[lits[i].cyc]), lits[i].en);
            if (lits[i].val >= 0) chk("model_valid", lits[i].cyc, int'(e_val[lits[i].cyc]), lits[i].val);
            if (lits[i].par >= 0) chk("model_par", lits[i].cyc, int'(e_par[lits[i].cyc]), lits[i].par);
            if (lits[i].stp >= 0) chk("model_stp", lits[i].cyc, int'(e_stp[lits[i].cyc]), lits[i].stp);
            if (lits[i].brk >= 0) chk("model_brk", lits[i].cyc, int'(e_brk[lits[i].cyc]), lits[i].brk);
            if (lits[i].dat >= 0) chk("model_data", lits[i].cyc, e_dat[lits[i].cyc], lits[i].dat);
        end

        drive(0);
        fork
            begin
                for (int c = 1; c < N; c++) begin
                    @(posedge clk);
                    #1;
                    drive(c);
                end
            end
            begin
                for (int c = 1; c < N; c++) begin
                    @(negedge clk);
                    compare(c);
                end
            end
        join
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
